// File: rtl/nx1_pcm_i2s.sv
// Stereo PCM to I2S serialiser with a one-entry pending buffer and per-frame sample request.
// Optional sticky overrun/underrun flags are built when NX1_PCM_I2S_STATUS_EN is defined.
module nx1_pcm_i2s #(
  parameter int BCLK_DIV = 4
) (
  input  logic        slot_sysclk,
  input  logic        slot_reset,
  input  logic [15:0] pcm_lch,
  input  logic [15:0] pcm_rch,
  input  logic        pcm_load,
  output logic        sample_req,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sdata,
  output logic        stat_ovr,
  output logic        stat_udr
);

  logic [7:0]  r_div_cnt;
  logic        r_bclk;
  logic [5:0]  r_bit_cnt;
  logic        r_lrck;
  logic        r_sdata;
  logic        r_req;
  logic [15:0] r_frame_l;
  logic [15:0] r_frame_r;
  logic [15:0] r_pend_l;
  logic [15:0] r_pend_r;
  logic        r_pend_v;

  logic        w_tc;
  logic        w_fall;
  logic        w_wrap;
  logic        w_take;
  logic [5:0]  w_next_bit;
  logic [15:0] w_frame_l_nx;
  logic [15:0] w_frame_r_nx;
  logic [15:0] w_word;
  logic [4:0]  w_pos;
  logic [3:0]  w_idx;
  logic        w_sbit;

  assign w_tc         = (r_div_cnt == 8'(BCLK_DIV - 1));
  assign w_fall       = w_tc & r_bclk;
  assign w_wrap       = w_fall & (r_bit_cnt == 6'd63);
  assign w_take       = w_wrap & r_pend_v;
  assign w_next_bit   = r_bit_cnt + 6'd1;
  assign w_frame_l_nx = w_take ? r_pend_l : r_frame_l;
  assign w_frame_r_nx = w_take ? r_pend_r : r_frame_r;
  assign w_pos        = w_next_bit[4:0];
  assign w_idx        = 4'(5'd16 - w_pos);

  // Bit to present after this fall tick: one-BCLK delay, MSB first, zero padding.
  always_comb begin
    w_word = w_next_bit[5] ? w_frame_r_nx : w_frame_l_nx;
    w_sbit = 1'b0;
    if ((w_pos >= 5'd1) && (w_pos <= 5'd16)) begin
      w_sbit = w_word[w_idx];
    end else begin
      w_sbit = 1'b0;
    end
  end

  always_ff @(posedge slot_sysclk) begin
    if (slot_reset) begin
      r_div_cnt <= 8'd0;
      r_bclk    <= 1'b0;
      r_bit_cnt <= 6'd0;
      r_lrck    <= 1'b0;
      r_sdata   <= 1'b0;
      r_req     <= 1'b0;
      r_frame_l <= 16'd0;
      r_frame_r <= 16'd0;
      r_pend_l  <= 16'd0;
      r_pend_r  <= 16'd0;
      r_pend_v  <= 1'b0;
    end else begin
      if (w_tc) begin
        r_div_cnt <= 8'd0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + 8'd1;
      end
      if (w_fall) begin
        r_bit_cnt <= w_next_bit;
        r_lrck    <= w_next_bit[5];
        r_sdata   <= w_sbit;
      end
      r_req     <= w_wrap;
      r_frame_l <= w_frame_l_nx;
      r_frame_r <= w_frame_r_nx;
      // A load in the wrap cycle refills the slot the frame just emptied.
      if (pcm_load) begin
        r_pend_l <= pcm_lch;
        r_pend_r <= pcm_rch;
        r_pend_v <= 1'b1;
      end else if (w_take) begin
        r_pend_v <= 1'b0;
      end
    end
  end

`ifdef NX1_PCM_I2S_STATUS_EN
  logic r_ovr;
  logic r_udr;
  logic w_ovr_evt;
  logic w_udr_evt;

  assign w_ovr_evt = pcm_load & r_pend_v & ~w_wrap;
  assign w_udr_evt = w_wrap & ~r_pend_v;

  always_ff @(posedge slot_sysclk) begin
    if (slot_reset) begin
      r_ovr <= 1'b0;
      r_udr <= 1'b0;
    end else begin
      r_ovr <= r_ovr | w_ovr_evt;
      r_udr <= r_udr | w_udr_evt;
    end
  end

  assign stat_ovr = r_ovr;
  assign stat_udr = r_udr;
`else
  assign stat_ovr = 1'b0;
  assign stat_udr = 1'b0;
`endif

  assign sample_req = r_req;
  assign i2s_bclk   = r_bclk;
  assign i2s_lrck   = r_lrck;
  assign i2s_sdata  = r_sdata;

endmodule

// File: tb/tb_nx1_pcm_i2s.sv
// Self-checking bench for nx1_pcm_i2s: directed scenarios plus random loads against a
// cycle-count based reference model (timing derived from the edge count since reset).
module tb_nx1_pcm_i2s;
  localparam int D = 4;
  localparam int FRAME = 128 * D;

  logic        slot_sysclk = 1'b0;
  logic        slot_reset;
  logic [15:0] pcm_lch;
  logic [15:0] pcm_rch;
  logic        pcm_load;
  logic        sample_req;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_sdata;
  logic        stat_ovr;
  logic        stat_udr;

  nx1_pcm_i2s #(.BCLK_DIV(D)) dut (
    .slot_sysclk(slot_sysclk), .slot_reset(slot_reset),
    .pcm_lch(pcm_lch), .pcm_rch(pcm_rch), .pcm_load(pcm_load),
    .sample_req(sample_req), .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck),
    .i2s_sdata(i2s_sdata), .stat_ovr(stat_ovr), .stat_udr(stat_udr)
  );

  always #5 slot_sysclk = ~slot_sysclk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          m_n;
  logic [15:0] m_frame [2];
  logic [15:0] m_pend [2];
  logic        m_pv;
  logic        m_req, m_bclk, m_lrck, m_sdata, m_ovr, m_udr;
  logic [15:0] cap [2];
  logic        flags_on;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (model cycle %0d)", tag, obs, exp, m_n);
    end
  endtask

  task automatic model_edge(input logic rst, input logic ld, input logic [15:0] l, input logic [15:0] r);
    int b, p, c;
    logic [15:0] w;
    logic old_pv;
    if (rst) begin
      m_n = 0; m_frame[0] = 16'd0; m_frame[1] = 16'd0; m_pend[0] = 16'd0; m_pend[1] = 16'd0;
      m_pv = 1'b0; m_req = 1'b0; m_bclk = 1'b0; m_lrck = 1'b0; m_sdata = 1'b0;
      m_ovr = 1'b0; m_udr = 1'b0;
    end else begin
      m_n++;
      old_pv = m_pv;
      m_req = ((m_n % FRAME) == 0);
      if (m_req) begin
        if (m_pv) begin
          m_frame[0] = m_pend[0]; m_frame[1] = m_pend[1]; m_pv = 1'b0;
        end else if (flags_on) begin
          m_udr = 1'b1;
        end
      end
      if (ld) begin
        if (old_pv && !m_req && flags_on) m_ovr = 1'b1;
        m_pend[0] = l; m_pend[1] = r; m_pv = 1'b1;
      end
      m_bclk = ((m_n / D) % 2) == 1;
      if ((m_n % (2 * D)) == 0) begin
        b = (m_n / (2 * D)) % 64;
        p = b % 32;
        c = b / 32;
        w = m_frame[c];
        m_lrck = (c == 1);
        m_sdata = (p >= 1 && p <= 16) ? w[16 - p] : 1'b0;
        if (p >= 1 && p <= 16) cap[c] = {cap[c][14:0], i2s_sdata_after()};
      end
    end
  endtask

  // Shift-in helper: the DUT bit is written into cap after the edge settles (see tick).
  function automatic logic i2s_sdata_after();
    return 1'b0;
  endfunction

  task automatic tick(input logic rst, input logic ld, input logic [15:0] l, input logic [15:0] r);
    int b, p, c;
    slot_reset = rst; pcm_load = ld; pcm_lch = l; pcm_rch = r;
    @(posedge slot_sysclk);
    model_edge(rst, ld, l, r);
    #1;
    check_val("outs", {26'd0, sample_req, i2s_bclk, i2s_lrck, i2s_sdata, stat_ovr, stat_udr},
              {26'd0, m_req, m_bclk, m_lrck, m_sdata, m_ovr, m_udr});
    if (!rst && (m_n % (2 * D)) == 0) begin
      b = (m_n / (2 * D)) % 64;
      p = b % 32;
      c = b / 32;
      if (p >= 1 && p <= 16) cap[c][0] = i2s_sdata;
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  task automatic run_to_wrap();
    int k;
    k = 0;
    do begin
      tick(1'b0, 1'b0, 16'd0, 16'd0);
      k++;
    end while (!m_req && k < FRAME + 8);
    check_val("wrap_reached", {31'd0, m_req}, 32'd1);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 16'd0, 16'd0);
    tick(1'b1, 1'b1, 16'hDEAD, 16'hBEEF);
  endtask

  initial begin
    logic prev_req;
    logic [15:0] v;
    logic ld;
`ifdef NX1_PCM_I2S_STATUS_EN
    flags_on = 1'b1;
`else
    flags_on = 1'b0;
`endif
    cap[0] = 16'd0; cap[1] = 16'd0;
    m_n = 0;

    // 1: no loads for two frames
    do_reset();
    check_val("reset_outs", {26'd0, sample_req, i2s_bclk, i2s_lrck, i2s_sdata, stat_ovr, stat_udr}, 32'd0);
    idle(2 * FRAME + 4);
    check_val("idle_udr", {31'd0, stat_udr}, {31'd0, flags_on});
    check_val("idle_ovr", {31'd0, stat_ovr}, 32'd0);

    // 2: single load before the first wrap
    do_reset();
    idle(10);
    tick(1'b0, 1'b1, 16'hA5C3, 16'h8001);
    run_to_wrap();
    run_to_wrap();
    check_val("single_l", {16'd0, cap[0]}, 32'h0000A5C3);
    check_val("single_r", {16'd0, cap[1]}, 32'h00008001);

    // 3: ramp, one load per sample request
    do_reset();
    v = 16'd0;
    prev_req = 1'b1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      ld = prev_req;
      tick(1'b0, ld, v, ~v);
      if (ld) v = v + 16'd1;
      prev_req = m_req;
    end
    check_val("ramp_ovr", {31'd0, stat_ovr}, 32'd0);
    check_val("ramp_udr", {31'd0, stat_udr}, 32'd0);

    // 4: two loads inside one frame, newest wins
    do_reset();
    idle(20);
    tick(1'b0, 1'b1, 16'h1111, 16'h1111);
    idle(30);
    tick(1'b0, 1'b1, 16'h2222, 16'h2222);
    run_to_wrap();
    run_to_wrap();
    check_val("ovr_word", {16'd0, cap[0]}, 32'h00002222);
    check_val("ovr_flag", {31'd0, stat_ovr}, {31'd0, flags_on});

    // 5: load in the exact wrap cycle
    do_reset();
    tick(1'b0, 1'b1, 16'h0F0F, 16'h0F0F);
    while (((m_n + 1) % FRAME) != 0) tick(1'b0, 1'b0, 16'd0, 16'd0);
    tick(1'b0, 1'b1, 16'h7FFF, 16'h7FFF);
    check_val("wrap_req", {31'd0, sample_req}, 32'd1);
    run_to_wrap();
    check_val("wrap_cur", {16'd0, cap[0]}, 32'h00000F0F);
    run_to_wrap();
    check_val("wrap_next", {16'd0, cap[1]}, 32'h00007FFF);
    check_val("wrap_flags", {30'd0, stat_ovr, stat_udr}, {30'd0, 1'b0, flags_on});

    // 6: random loads, then reset at bit_cnt 40
    do_reset();
    for (int i = 0; i < 3 * FRAME; i++) begin
      ld = ($urandom_range(0, 199) == 0);
      tick(1'b0, ld, 16'($urandom), 16'($urandom));
    end
    while (((m_n / (2 * D)) % 64) != 40) tick(1'b0, 1'b0, 16'd0, 16'd0);
    tick(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    check_val("midreset", {26'd0, sample_req, i2s_bclk, i2s_lrck, i2s_sdata, stat_ovr, stat_udr}, 32'd0);
    idle(FRAME + 4);
    check_val("post_reset_udr", {31'd0, stat_udr}, {31'd0, flags_on});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1, "timeout");
  end
endmodule
